// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, widths and FSM states.
package alu_pkg;

    localparam int DATA_W   = 8;
    localparam int RESULT_W = 16;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] MUL  = 3'd2;
    localparam logic [2:0] AND  = 3'd3;
    localparam logic [2:0] OR   = 3'd4;
    localparam logic [2:0] NAND = 3'd5;
    localparam logic [2:0] NOR  = 3'd6;
    localparam logic [2:0] XOR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Only the arithmetic add/subtract ops produce a meaningful carry bit.
    function automatic logic has_carry(input logic [2:0] code);
        return (code == ADD) || (code == SUB);
    endfunction

endpackage

// File: rtl/ALU_8.sv
// Combinational 8-bit ALU with 16-bit result; carry is result bit 8.
module ALU_8
    import alu_pkg::*;
(
    input  logic [2:0]          code,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [RESULT_W-1:0] out,
    output logic                zero,
    output logic                carry
);

    logic [DATA_W-1:0] lo;

    always_comb begin
        lo  = '0;
        out = '0;
        case (code)
            ADD:     out = RESULT_W'(a) + RESULT_W'(b);
            SUB:     out = RESULT_W'(a) - RESULT_W'(b);
            MUL:     out = RESULT_W'(a) * RESULT_W'(b);
            default: begin
                // Logic ops are formed at operand width so inversion stays in the low byte.
                case (code)
                    AND:     lo = a & b;
                    OR:      lo = a | b;
                    NAND:    lo = ~(a & b);
                    NOR:     lo = ~(a | b);
                    default: lo = a ^ b;
                endcase
                out = {{(RESULT_W-DATA_W){1'b0}}, lo};
            end
        endcase
        zero  = (out == '0);
        carry = out[DATA_W];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU_8 between two requesters, one op in flight.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic [OP_W-1:0]     req0_code,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [OP_W-1:0]     req1_code,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    output logic                req1_ready,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [RESULT_W-1:0] rsp_out,
    output logic                rsp_carry,
    output logic                rsp_zero,
    input  logic                rsp_ready,
    output logic                busy,
    output logic [15:0]         ops_done
);

    state_t              state, state_nxt;
    logic                rr_last;
    logic                grant;
    logic                accept;
    logic [OP_W-1:0]     op_code;
    logic [DATA_W-1:0]   op_a, op_b;
    logic                op_id;
    logic [RESULT_W-1:0] alu_out;
    logic                alu_zero, alu_carry;

    ALU_8 u_alu (
        .code  (op_code),
        .a     (op_a),
        .b     (op_b),
        .out   (alu_out),
        .zero  (alu_zero),
        .carry (alu_carry)
    );

    always_comb begin
        // On a tie the requester that was not served last wins.
        grant      = (req0_valid && req1_valid) ? ~rr_last : req1_valid;
        req0_ready = rst_n && (state == IDLE) && (req0_valid || req1_valid) && !grant;
        req1_ready = rst_n && (state == IDLE) && (req0_valid || req1_valid) && grant;
        accept     = req0_ready || req1_ready;
        state_nxt  = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            ops_done  <= '0;
            op_code   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_out   <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_code <= grant ? req1_code : req0_code;
                op_a    <= grant ? req1_a    : req0_a;
                op_b    <= grant ? req1_b    : req0_b;
                op_id   <= grant;
                rr_last <= grant;
            end
            if (state == EXEC) begin
                rsp_id    <= op_id;
                rsp_out   <= alu_out;
                rsp_zero  <= alu_zero;
                rsp_carry <= has_carry(op_code) && alu_carry;
            end
            if (rsp_valid && rsp_ready)
                ops_done <= ops_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic vs a transaction model.
module tb_alu_arbiter;

    localparam logic [2:0] K_ADD = 3'd0, K_SUB = 3'd1, K_MUL = 3'd2, K_AND = 3'd3;
    localparam logic [2:0] K_OR  = 3'd4, K_NOR = 3'd6, K_XOR = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]  req0_code, req1_code;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_ready, busy;
    logic [15:0] rsp_out, ops_done;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(8), .OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_code(req0_code), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_code(req1_code), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .rsp_ready(rsp_ready), .busy(busy), .ops_done(ops_done)
    );

    int unsigned n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result {carry, zero, out[15:0]} from the arithmetic definition of each opcode.
    function automatic logic [17:0] ref_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        int unsigned ia, ib, r;
        logic        cy;
        logic [15:0] o;
        ia = a; ib = b; cy = 1'b0;
        case (c)
            3'd0: begin r = ia + ib; cy = (ia + ib) > 255; end
            3'd1: begin r = ia - ib; cy = ia < ib; end
            3'd2: r = ia * ib;
            3'd3: r = ia & ib;
            3'd4: r = ia | ib;
            3'd5: r = ~(ia & ib) & 32'hFF;
            3'd6: r = ~(ia | ib) & 32'hFF;
            default: r = ia ^ ib;
        endcase
        o = 16'(r);
        return {cy, (o == 16'h0000), o};
    endfunction

    // Transaction model: one outstanding op, age counts cycles since accept.
    logic        m_busy, m_last;
    int unsigned m_age;
    logic [15:0] m_ops;
    logic [18:0] exq[$];
    logic [18:0] rsp_log[$];
    int unsigned acc0_cnt = 0, acc1_cnt = 0, rsp_cnt = 0;
    int unsigned preload_cnt = 0, preload_seen = 0;

    always @(negedge clk) begin
        logic        e0, e1;
        logic [18:0] e;
        if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_ops = 16'h0000;
            exq.delete();
        end else begin
            if (preload_cnt != preload_seen) begin
                preload_seen = preload_cnt;
                m_ops = 16'hFFFF;
            end
            e0 = 1'b0; e1 = 1'b0;
            if (!m_busy) begin
                if (req0_valid && req1_valid) begin
                    if (m_last) e0 = 1'b1; else e1 = 1'b1;
                end else if (req0_valid) e0 = 1'b1;
                else if (req1_valid) e1 = 1'b1;
            end
            check("req0_ready", 32'(req0_ready), 32'(e0));
            check("req1_ready", 32'(req1_ready), 32'(e1));
            check("busy", 32'(busy), 32'(m_busy));
            check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
            check("ops_done", 32'(ops_done), 32'(m_ops));
            if (m_busy) begin
                if (m_age >= 2 && exq.size() > 0) begin
                    e = exq[0];
                    check("rsp_id", 32'(rsp_id), 32'(e[18]));
                    check("rsp_carry", 32'(rsp_carry), 32'(e[17]));
                    check("rsp_zero", 32'(rsp_zero), 32'(e[16]));
                    check("rsp_out", 32'(rsp_out), 32'(e[15:0]));
                    if (rsp_ready) begin
                        rsp_log.push_back({rsp_id, rsp_carry, rsp_zero, rsp_out});
                        void'(exq.pop_front());
                        m_ops++;
                        rsp_cnt++;
                        m_busy = 1'b0;
                    end
                end else begin
                    m_age++;
                end
            end else if (e0 || e1) begin
                if (e0) begin
                    exq.push_back({1'b0, ref_op(req0_code, req0_a, req0_b)});
                    acc0_cnt++;
                end else begin
                    exq.push_back({1'b1, ref_op(req1_code, req1_a, req1_b)});
                    acc1_cnt++;
                end
                m_busy = 1'b1; m_age = 1; m_last = e1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        int unsigned s;
        s = id ? acc1_cnt : acc0_cnt;
        if (id) begin req1_code = c; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else    begin req0_code = c; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        for (int k = 0; k < 40; k++) begin
            step();
            if ((id ? acc1_cnt : acc0_cnt) != s) break;
        end
        check("send_accept", id ? acc1_cnt : acc0_cnt, s + 1);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [2:0] c0, input logic [7:0] a0, input logic [7:0] b0,
                             input logic [2:0] c1, input logic [7:0] a1, input logic [7:0] b1);
        int unsigned s0, s1;
        s0 = acc0_cnt; s1 = acc1_cnt;
        req0_code = c0; req0_a = a0; req0_b = b0; req0_valid = 1'b1;
        req1_code = c1; req1_a = a1; req1_b = b1; req1_valid = 1'b1;
        for (int k = 0; k < 40 && (req0_valid || req1_valid); k++) begin
            step();
            if (acc0_cnt != s0) req0_valid = 1'b0;
            if (acc1_cnt != s1) req1_valid = 1'b0;
        end
        check("pair_accept", acc0_cnt + acc1_cnt, s0 + s1 + 2);
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int unsigned n);
        for (int k = 0; k < 40 && rsp_cnt < n; k++) step();
        check("rsp_count", rsp_cnt, n);
    endtask

    initial begin
        logic [18:0] e;
        int unsigned base, s1;
        logic [15:0] ops0;

        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_code = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_code = '0; req1_a = '0; req1_b = '0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_ops_done", 32'(ops_done), 0);
        rst_n = 1'b1;

        send(1'b0, K_ADD, 8'hFF, 8'h01);
        wait_rsp(1);
        e = rsp_log[0];
        check("add_id", 32'(e[18]), 0);
        check("add_out", 32'(e[15:0]), 32'h0100);
        check("add_carry", 32'(e[17]), 1);
        check("add_zero", 32'(e[16]), 0);
        check("add_ops", 32'(ops_done), 1);

        send(1'b1, K_SUB, 8'h10, 8'h20);
        wait_rsp(2);
        e = rsp_log[1];
        check("sub_id", 32'(e[18]), 1);
        check("sub_out", 32'(e[15:0]), 32'hFFF0);
        check("sub_carry", 32'(e[17]), 1);
        send(1'b1, K_MUL, 8'hAA, 8'h55);
        wait_rsp(3);
        e = rsp_log[2];
        check("mul_out", 32'(e[15:0]), 32'h3872);
        check("mul_carry", 32'(e[17]), 0);

        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        base = rsp_cnt;
        send_pair(K_XOR, 8'hAA, 8'hAA, K_OR, 8'h0F, 8'hF0);
        wait_rsp(base + 2);
        e = rsp_log[base];
        check("tie_first_id", 32'(e[18]), 0);
        check("xor_out", 32'(e[15:0]), 0);
        check("xor_zero", 32'(e[16]), 1);
        check("xor_carry", 32'(e[17]), 0);
        e = rsp_log[base + 1];
        check("tie_second_id", 32'(e[18]), 1);
        check("or_out", 32'(e[15:0]), 32'h00FF);
        check("or_zero", 32'(e[16]), 0);
        send_pair(K_ADD, 8'h01, 8'h01, K_ADD, 8'h02, 8'h02);
        wait_rsp(base + 4);
        e = rsp_log[base + 2];
        check("tie_again_id", 32'(e[18]), 0);

        // Response backpressure with a competing request waiting.
        rsp_ready = 1'b0; base = rsp_cnt;
        send(1'b0, K_ADD, 8'h12, 8'h34);
        s1 = acc1_cnt;
        req1_code = K_NOR; req1_a = 8'h0F; req1_b = 8'h30; req1_valid = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_busy", 32'(busy), 1);
            check("stall_out", 32'(rsp_out), 32'h0046);
            check("stall_ready0", 32'(req0_ready), 0);
            check("stall_ready1", 32'(req1_ready), 0);
            step();
        end
        ops0 = ops_done;
        rsp_ready = 1'b1;
        step();
        check("stall_ops", 32'(ops_done), 32'(16'(ops0 + 16'd1)));
        check("stall_idle", 32'(busy), 0);
        for (int k = 0; k < 10 && acc1_cnt == s1; k++) step();
        req1_valid = 1'b0;
        wait_rsp(base + 2);
        check("nor_out", 32'(rsp_log[base + 1][15:0]), 32'h00C0);

        // Reset while an op is in EXEC, with both requesters waiting.
        base = rsp_cnt;
        send(1'b1, K_ADD, 8'h03, 8'h04);
        req0_code = K_AND; req0_a = 8'h3C; req0_b = 8'h0F; req0_valid = 1'b1;
        req1_code = K_NOR; req1_a = 8'h00; req1_b = 8'h00; req1_valid = 1'b1;
        rst_n = 1'b0;
        step();
        check("rx_rsp_valid", 32'(rsp_valid), 0);
        check("rx_rsp_id", 32'(rsp_id), 0);
        check("rx_rsp_out", 32'(rsp_out), 0);
        check("rx_rsp_carry", 32'(rsp_carry), 0);
        check("rx_rsp_zero", 32'(rsp_zero), 0);
        check("rx_busy", 32'(busy), 0);
        check("rx_ready0", 32'(req0_ready), 0);
        check("rx_ready1", 32'(req1_ready), 0);
        check("rx_ops", 32'(ops_done), 0);
        check("rx_no_rsp", rsp_cnt, base);
        rst_n = 1'b1;
        send_pair(K_AND, 8'h3C, 8'h0F, K_NOR, 8'h00, 8'h00);
        wait_rsp(base + 2);
        check("rx_tie_id", 32'(rsp_log[base][18]), 0);
        check("and_out", 32'(rsp_log[base][15:0]), 32'h000C);
        check("nor0_out", 32'(rsp_log[base + 1][15:0]), 32'h00FF);

        // Counter wrap.
        force dut.ops_done = 16'hFFFF;
        preload_cnt++;
        step();
        release dut.ops_done;
        step();
        check("wrap_pre", 32'(ops_done), 32'hFFFF);
        base = rsp_cnt;
        send(1'b0, K_SUB, 8'h05, 8'h05);
        wait_rsp(base + 1);
        check("wrap_ops", 32'(ops_done), 0);

        // Random traffic against the model.
        begin
            int unsigned s0r, s1r;
            s0r = acc0_cnt; s1r = acc1_cnt;
            for (int cyc = 0; cyc < 600; cyc++) begin
                if (req0_valid && acc0_cnt != s0r) req0_valid = 1'b0;
                if (req1_valid && acc1_cnt != s1r) req1_valid = 1'b0;
                s0r = acc0_cnt; s1r = acc1_cnt;
                if (!req0_valid && $urandom_range(0, 2) != 0) begin
                    req0_valid = 1'b1; req0_code = 3'($urandom);
                    req0_a = 8'($urandom); req0_b = 8'($urandom);
                end
                if (!req1_valid && $urandom_range(0, 2) != 0) begin
                    req1_valid = 1'b1; req1_code = 3'($urandom);
                    req1_a = 8'($urandom); req1_b = 8'($urandom);
                end
                rsp_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            if (req0_valid && acc0_cnt != s0r) req0_valid = 1'b0;
            if (req1_valid && acc1_cnt != s1r) req1_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 40 && (req0_valid || req1_valid); k++) begin
            int unsigned a0, a1;
            a0 = acc0_cnt; a1 = acc1_cnt;
            step();
            if (acc0_cnt != a0) req0_valid = 1'b0;
            if (acc1_cnt != a1) req1_valid = 1'b0;
        end
        repeat (6) step();
        check("drain_busy", 32'(busy), 0);
        check("drain_queue", exq.size(), 0);
        check("drain_ops", 32'(ops_done), 32'(16'(rsp_cnt - 1 - base)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
